// File: rtl/ofdm_tx_pkg.sv
// Shared types, frame-layout constants and 802.11a training ROM tables (x64, rounded) for the TX frame assembler.
package ofdm_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STS,
    ST_LTS_GI,
    ST_LTS,
    ST_DATA,
    ST_DONE
  } tx_state_e;

  typedef enum logic {
    ROM_STS,
    ROM_LTS
  } rom_sel_e;

  localparam int STS_LEN      = 16;
  localparam int LTS_LEN      = 64;
  localparam int GI2_LEN      = 32;
  localparam int PREAMBLE_LEN = 320;
  localparam int ROM_W        = 8;

  localparam logic signed [ROM_W-1:0] STS_RE [STS_LEN] = '{
    3, -8, -1, 9, 6, 9, -1, -8, 3, 0, -5, -1, 0, -1, -5, 0};
  localparam logic signed [ROM_W-1:0] STS_IM [STS_LEN] = '{
    3, 0, -5, -1, 0, -1, -5, 0, 3, -8, -1, 9, 6, 9, -1, -8};

  localparam logic signed [ROM_W-1:0] LTS_RE [LTS_LEN] = '{
    10, 0, 3, 6, 1, 4, -7, -2, 6, 3, 0, -9, 2, 4, -1, 8,
    4, 2, -4, -8, 5, 4, -4, -4, -2, -8, -8, 5, 0, -6, 6, 1,
    -10, 1, 6, -6, 0, 5, -8, -8, -2, -4, -4, 4, 5, -8, -4, 2,
    4, 8, -1, 4, 2, -9, 0, 3, 6, -2, -7, 4, 1, 6, 3, 0};
  localparam logic signed [ROM_W-1:0] LTS_IM [LTS_LEN] = '{
    0, -8, -7, 5, 2, -6, -4, -7, -2, 0, -7, -3, -4, -1, 10, 0,
    -4, 6, 2, 4, 6, 1, 5, -1, -10, -1, -1, -5, 3, 7, 7, 6,
    0, -6, -7, -7, -3, 5, 1, 1, 10, 1, -5, -1, -6, -4, -2, -6,
    4, 0, -10, 1, 4, 3, 7, 0, 2, 7, 4, 6, -2, -5, 7, 8};

endpackage

// File: rtl/ofdm_training_rom.sv
// Combinational short/long training sequence lookup, sign-extended to the datapath width.
module ofdm_training_rom
  import ofdm_tx_pkg::*;
#(
  parameter int DW = 8
) (
  input  rom_sel_e             sel_i,
  input  logic [5:0]           addr_i,
  output logic signed [DW-1:0] re_o,
  output logic signed [DW-1:0] im_o
);

  always_comb begin
    if (sel_i == ROM_STS) begin
      re_o = DW'(STS_RE[addr_i[3:0]]);
      im_o = DW'(STS_IM[addr_i[3:0]]);
    end else begin
      re_o = DW'(LTS_RE[addr_i]);
      im_o = DW'(LTS_IM[addr_i]);
    end
  end

endmodule

// File: rtl/ofdm_preamble_inserter.sv
// TX frame assembler: gapless STS/GI2/LTS preamble from ROM, then NumSymbols handshaked data symbols.
// Build option TX_PREAMBLE_WINDOW_EN halves the first STS, first GI2 and first data sample.
module ofdm_preamble_inserter
  import ofdm_tx_pkg::*;
#(
  parameter int STS_REPS = 10,
  parameter int SYM_LEN  = 80,
  parameter int DW       = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 TxStart,
  input  logic [7:0]           NumSymbols,
  input  logic                 DataInEnable,
  input  logic signed [DW-1:0] DataInRe,
  input  logic signed [DW-1:0] DataInIm,
  output logic                 DataInReady,
  output logic                 DataOutEnable,
  output logic signed [DW-1:0] DataOutRe,
  output logic signed [DW-1:0] DataOutIm,
  output logic [6:0]           Data_out_index,
  output logic [7:0]           DataSymbol,
  output logic                 FrameBusy,
  output logic                 FrameDone
);

  localparam int STS_TOTAL = STS_REPS * STS_LEN;
`ifdef TX_PREAMBLE_WINDOW_EN
  localparam bit WINDOW_EN = 1'b1;
`else
  localparam bit WINDOW_EN = 1'b0;
`endif

  tx_state_e             state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            num_q, num_d;
  logic [7:0]            sym_q, sym_d;
  logic                  vld_q, vld_d;
  logic signed [DW-1:0]  re_q, re_d, im_q, im_d;
  logic [6:0]            idx_q, idx_d;
  logic                  xfer, win;
  rom_sel_e              rom_sel;
  logic [5:0]            rom_addr;
  logic signed [DW-1:0]  rom_re, rom_im;

  function automatic logic signed [DW-1:0] window_half(input logic signed [DW-1:0] x,
                                                        input logic en);
    return en ? (x >>> 1) : x;
  endfunction

  // Ready stays low once the last symbol has been taken so DATA can drain into DONE.
  assign DataInReady = (state_q == ST_DATA) && (sym_q != num_q);
  assign xfer        = DataInReady && DataInEnable;

  // state_q/cnt_q name the sample currently on the output; _d names the next one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    sym_d   = sym_q;
    unique case (state_q)
      ST_IDLE: if (TxStart) begin
        state_d = ST_STS;
        cnt_d   = '0;
        num_d   = NumSymbols;
        sym_d   = '0;
      end
      ST_STS: if (cnt_q == 8'(STS_TOTAL - 1)) begin
        state_d = ST_LTS_GI;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 8'd1;
      ST_LTS_GI: if (cnt_q == 8'(GI2_LEN - 1)) begin
        state_d = ST_LTS;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 8'd1;
      ST_LTS: if (cnt_q == 8'(2 * LTS_LEN - 1)) begin
        state_d = (num_q == 8'd0) ? ST_DONE : ST_DATA;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 8'd1;
      ST_DATA: if (xfer) begin
        if (cnt_q == 8'(SYM_LEN - 1)) begin
          cnt_d = '0;
          sym_d = sym_q + 8'd1;
        end else cnt_d = cnt_q + 8'd1;
      end else if (sym_q == num_q) begin
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rom_sel  = ROM_STS;
    rom_addr = {2'b00, cnt_d[3:0]};
    if (state_d == ST_LTS_GI) begin
      rom_sel  = ROM_LTS;
      rom_addr = 6'(LTS_LEN - GI2_LEN) + cnt_d[5:0];
    end else if (state_d == ST_LTS) begin
      rom_sel  = ROM_LTS;
      rom_addr = cnt_d[5:0];
    end
  end

  ofdm_training_rom #(.DW(DW)) u_rom (
    .sel_i  (rom_sel),
    .addr_i (rom_addr),
    .re_o   (rom_re),
    .im_o   (rom_im)
  );

  always_comb begin
    vld_d = 1'b0;
    re_d  = re_q;
    im_d  = im_q;
    idx_d = idx_q;
    win   = 1'b0;
    if (state_d inside {ST_STS, ST_LTS_GI, ST_LTS}) begin
      vld_d = 1'b1;
      win   = WINDOW_EN && (state_d != ST_LTS) && (cnt_d == 8'd0);
      re_d  = window_half(rom_re, win);
      im_d  = window_half(rom_im, win);
      idx_d = {1'b0, rom_addr};
    end else if (xfer) begin
      vld_d = 1'b1;
      win   = WINDOW_EN && (sym_q == 8'd0) && (cnt_q == 8'd0);
      re_d  = window_half(DataInRe, win);
      im_d  = window_half(DataInIm, win);
      idx_d = cnt_q[6:0];
    end
  end

  // Output register stage
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      sym_q   <= '0;
      vld_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      sym_q   <= sym_d;
      vld_q   <= vld_d;
      re_q    <= re_d;
      im_q    <= im_d;
      idx_q   <= idx_d;
    end
  end

  assign DataOutEnable  = vld_q;
  assign DataOutRe      = re_q;
  assign DataOutIm      = im_q;
  assign Data_out_index = idx_q;
  assign DataSymbol     = sym_q;
  assign FrameBusy      = (state_q != ST_IDLE);
  assign FrameDone      = (state_q == ST_DONE);

endmodule
